// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: IR opcode and memory handshake in,
// datapath selects, write strobes and status out.
interface multicycle_control_unit_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            mem_ready;
  logic            mem_req;
  logic            IorD;
  logic            MemWrite;
  logic            IRWrite;
  logic            PCWrite;
  logic            Branch;
  logic [1:0]      PCSrc;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic            RegDst;
  logic            MemtoReg;
  logic            RegWrite;
  logic            instr_done;
  logic            illegal_op;
  logic [3:0]      state_o;

  modport master (
    input  opcode, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite,
    output PCWrite, Branch, PCSrc, ALUSrcA,
    output ALUSrcB, ALUOp, RegDst, MemtoReg,
    output RegWrite, instr_done, illegal_op,
    output state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite,
    input  PCWrite, Branch, PCSrc, ALUSrcA,
    input  ALUSrcB, ALUOp, RegDst, MemtoReg,
    input  RegWrite, instr_done, illegal_op,
    input  state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM. Ports: clk, rst_n (async low),
// bus (master modport). Define MCU_JUMP_EN to decode OP_J.
module multicycle_control_unit #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] OP_R    = 6'b000000,
  parameter logic [OP_W-1:0] OP_LW   = 6'b100011,
  parameter logic [OP_W-1:0] OP_SW   = 6'b101011,
  parameter logic [OP_W-1:0] OP_BEQ  = 6'b000100,
  parameter logic [OP_W-1:0] OP_ADDI = 6'b001000,
  parameter logic [OP_W-1:0] OP_J    = 6'b000010
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  state_t state;
  state_t nxt;

  logic [OP_W-1:0] op;
  logic            rdy;

  assign op          = bus.opcode;
  assign rdy         = bus.mem_ready;
  assign bus.state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt            = state;
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    unique case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = rdy;
        bus.PCWrite = rdy;
        if (rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW):
            nxt = S_MEMADR;
          op == OP_R:    nxt = S_EXECUTE;
          op == OP_BEQ:  nxt = S_BRANCH;
          op == OP_ADDI: nxt = S_ADDIEX;
`ifdef MCU_JUMP_EN
          op == OP_J:    nxt = S_JUMP;
`else
          op == OP_J: begin
            nxt            = S_FETCH;
            bus.illegal_op = 1'b1;
          end
`endif
          default: begin
            nxt            = S_FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        // IR holds the opcode, so lw/sw is still visible here
        nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.IorD    = 1'b1;
        if (rdy) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_req    = 1'b1;
        bus.IorD       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = rdy;
        if (rdy) nxt = S_FETCH;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUOp      = 2'b01;
        bus.PCSrc      = 2'b01;
        bus.Branch     = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        nxt         = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        bus.PCSrc      = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = S_FETCH;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: reset, per-cycle
// output model, cycle-count table, stalls, async reset.
module tb_multicycle_control_unit;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

`ifdef MCU_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  localparam int IDLE = 0, FETCH = 1, DECODE = 2;
  localparam int MEMADR = 3, MEMRD = 4, MEMWB = 5;
  localparam int MEMWR = 6, EXECUTE = 7, ALUWB = 8;
  localparam int BRANCH = 9, ADDIEX = 10, ADDIWB = 11;
  localparam int JUMP = 12;

  typedef struct packed {
    logic       mem_req;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] st;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   cyc;
  int   last_done;

  multicycle_control_unit_if #(.OP_W(6)) bus ();

  multicycle_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t dut_out();
    ctl_t c;
    c.mem_req    = bus.mem_req;
    c.IorD       = bus.IorD;
    c.MemWrite   = bus.MemWrite;
    c.IRWrite    = bus.IRWrite;
    c.PCWrite    = bus.PCWrite;
    c.Branch     = bus.Branch;
    c.PCSrc      = bus.PCSrc;
    c.ALUSrcA    = bus.ALUSrcA;
    c.ALUSrcB    = bus.ALUSrcB;
    c.ALUOp      = bus.ALUOp;
    c.RegDst     = bus.RegDst;
    c.MemtoReg   = bus.MemtoReg;
    c.RegWrite   = bus.RegWrite;
    c.instr_done = bus.instr_done;
    c.illegal_op = bus.illegal_op;
    c.st         = bus.state_o;
    return c;
  endfunction

  function automatic bit legal(logic [5:0] op);
    if (op == R || op == LW || op == SW) return 1'b1;
    if (op == BEQ || op == ADDI) return 1'b1;
    return JEN && (op == J);
  endfunction

  // Expected outputs for one cycle, straight from the phase table
  function automatic ctl_t model(int s, bit rdy, logic [5:0] op);
    ctl_t c;
    c    = '0;
    c.st = 4'(s);
    case (s)
      FETCH: begin
        c.mem_req = 1; c.ALUSrcB = 2'b01;
        c.IRWrite = rdy; c.PCWrite = rdy;
      end
      DECODE: begin
        c.ALUSrcB = 2'b11; c.illegal_op = !legal(op);
      end
      MEMADR: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
      MEMRD: begin c.mem_req = 1; c.IorD = 1; end
      MEMWB: begin
        c.RegWrite = 1; c.MemtoReg = 1; c.instr_done = 1;
      end
      MEMWR: begin
        c.mem_req = 1; c.IorD = 1; c.MemWrite = 1;
        c.instr_done = rdy;
      end
      EXECUTE: begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
      ALUWB: begin
        c.RegDst = 1; c.RegWrite = 1; c.instr_done = 1;
      end
      BRANCH: begin
        c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCSrc = 2'b01;
        c.Branch = 1; c.instr_done = 1;
      end
      ADDIEX: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
      ADDIWB: begin c.RegWrite = 1; c.instr_done = 1; end
      JUMP: begin
        c.PCSrc = 2'b10; c.PCWrite = 1; c.instr_done = 1;
      end
      default: c.st = 4'(s);
    endcase
    return c;
  endfunction

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got %0d want %0d", nm, got, want);
  endtask

  task automatic chk_ctl(string nm, ctl_t got, ctl_t want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got %h want %h", nm, got, want);
  endtask

  // One clock: drive at posedge+1, compare at negedge
  task automatic step(int s, bit rdy, logic [5:0] op);
    bus.mem_ready = rdy;
    bus.opcode    = op;
    @(negedge clk);
    cyc++;
    if (bus.instr_done) last_done = cyc;
    chk_ctl($sformatf("st%0d_op%0h", s, op),
            dut_out(), model(s, rdy, op));
    @(posedge clk);
    #1;
  endtask

  function automatic bit rr(bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Expected phase walk of one instruction, from FETCH on
  task automatic run_instr(logic [5:0] op, int fs, int ms,
                           bit rnd);
    int ms_state;
    for (int i = 0; i < fs; i++) step(FETCH, 1'b0, op);
    step(FETCH, 1'b1, op);
    step(DECODE, rr(rnd), op);
    if (!legal(op)) return;
    if (op == LW || op == SW) begin
      ms_state = (op == LW) ? MEMRD : MEMWR;
      step(MEMADR, rr(rnd), op);
      for (int i = 0; i < ms; i++) step(ms_state, 1'b0, op);
      step(ms_state, 1'b1, op);
      if (op == LW) step(MEMWB, rr(rnd), op);
    end else if (op == R) begin
      step(EXECUTE, rr(rnd), op);
      step(ALUWB, rr(rnd), op);
    end else if (op == BEQ) begin
      step(BRANCH, rr(rnd), op);
    end else if (op == ADDI) begin
      step(ADDIEX, rr(rnd), op);
      step(ADDIWB, rr(rnd), op);
    end else begin
      step(JUMP, rr(rnd), op);
    end
  endtask

  initial begin
    vec_t       tbl[7];
    logic [5:0] pool[8];
    logic [5:0] op;
    int         cnt;
    bit         hit;

    checks    = 0;
    passes    = 0;
    cyc       = 0;
    last_done = -1;

    tbl[0] = '{R, 4};
    tbl[1] = '{LW, 5};
    tbl[2] = '{SW, 4};
    tbl[3] = '{BEQ, 3};
    tbl[4] = '{ADDI, 4};
    tbl[5] = '{J, JEN ? 3 : 2};
    tbl[6] = '{BAD, 2};

    pool[0] = R;   pool[1] = LW;  pool[2] = SW;
    pool[3] = BEQ; pool[4] = ADDI; pool[5] = J;
    pool[6] = BAD; pool[7] = 6'h15;

    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = R;
    repeat (3) begin
      @(negedge clk);
      chk_ctl("reset", dut_out(), model(IDLE, 1'b1, R));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(IDLE, 1'b1, R);

    run_instr(R, 0, 0, 1'b0);
    run_instr(LW, 0, 0, 1'b0);
    run_instr(SW, 0, 0, 1'b0);
    run_instr(BEQ, 0, 0, 1'b0);
    run_instr(ADDI, 0, 0, 1'b0);

    foreach (tbl[k]) begin
      cnt = 0;
      hit = 1'b0;
      while (cnt < 20 && !hit) begin
        bus.mem_ready = 1'b1;
        bus.opcode    = tbl[k].op;
        @(negedge clk);
        cnt++;
        hit = bus.instr_done || bus.illegal_op;
        @(posedge clk);
        #1;
      end
      chk($sformatf("cycles_op%0h", tbl[k].op),
          cnt, tbl[k].cycles);
      chk($sformatf("refetch_op%0h", tbl[k].op),
          int'(bus.state_o), FETCH);
    end

    cyc       = 0;
    last_done = -1;
    run_instr(LW, 2, 3, 1'b0);
    chk("lw_stall_len", last_done, 10);

    run_instr(BAD, 0, 0, 1'b0);
    run_instr(J, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = pool[$urandom_range(0, 7)];
      run_instr(op, $urandom_range(0, 2),
                $urandom_range(0, 2), 1'b1);
    end

    step(FETCH, 1'b1, SW);
    step(DECODE, 1'b1, SW);
    step(MEMADR, 1'b1, SW);
    bus.mem_ready = 1'b0;
    #2;
    chk_ctl("memwr_stall", dut_out(), model(MEMWR, 1'b0, SW));
    rst_n = 1'b0;
    #1;
    chk_ctl("async_rst", dut_out(), model(IDLE, 1'b0, SW));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_ctl("rst_hold", dut_out(), model(IDLE, 1'b0, SW));
    rst_n = 1'b1;
    step(IDLE, 1'b1, R);
    run_instr(R, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
